// File: rtl/data_memory_storer.sv
// data_memory_storer
//
// Store side of the data-memory path. Takes one store request at a time from
// the MEM stage and commits it to a word-wide RAM that has no byte enables.
// Word stores are written straight through. Byte and halfword stores read the
// target word, merge the new lane into it, and write the whole word back.
// Misaligned requests raise a one-cycle flag and never touch the RAM.
//
// Ports
//   clk_in          sole clock, rising edge
//   reset_n_in      asynchronous active-low reset
//   req_valid_in    store request present
//   req_ready_out   block idle; a request is accepted on valid && ready
//   addr_in         byte address of the store
//   data_in         right-justified store data
//   size_in         00 byte, 01 half, 1x word
//   done_out        one-cycle pulse during the RAM write cycle
//   misaligned_out  one-cycle pulse for a rejected misaligned request
//   mem_addr_out    RAM word address (captured addr[31:2])
//   mem_re_out      RAM read strobe; mem_rdata_in is valid the next cycle
//   mem_rdata_in    RAM read data
//   mem_we_out      RAM write strobe; commits at the end of the cycle
//   mem_wdata_out   RAM write data

module data_memory_storer (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  size_in,
    output logic        done_out,
    output logic        misaligned_out,
    output logic [29:0] mem_addr_out,
    output logic        mem_re_out,
    input  logic [31:0] mem_rdata_in,
    output logic        mem_we_out,
    output logic [31:0] mem_wdata_out
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [31:0] merged_q, merged_d;
    logic        accept;

    assign accept = req_valid_in && (state_q == IDLE);

    // Next-state selection. At accept the size/alignment combination picks
    // the path: aligned words write directly, halfwords and bytes go through
    // the read-modify-write sequence, anything misaligned goes to ERROR.
    // size_in[1] set means a word store (2'b10 is treated as a word).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (size_in[1]) begin
                        state_d = (addr_in[1:0] == 2'b00) ? WRITE : ERROR;
                    end else if (size_in[0]) begin
                        state_d = addr_in[0] ? ERROR : READ;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = MERGE;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane merge: the RAM word arrives in MERGE (one cycle after the read
    // strobe), and only the addressed byte/halfword lane is replaced.
    always_comb begin
        merged_d = mem_rdata_in;
        if (size_q[0]) begin
            if (addr_q[1]) merged_d[31:16] = data_q[15:0];
            else           merged_d[15:0]  = data_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    merged_d[7:0]   = data_q[7:0];
                2'd1:    merged_d[15:8]  = data_q[7:0];
                2'd2:    merged_d[23:16] = data_q[7:0];
                default: merged_d[31:24] = data_q[7:0];
            endcase
        end
    end

    // State and request capture. The request registers only load on accept,
    // which keeps mem_addr_out stable for the whole operation.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            size_q   <= '0;
            merged_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= addr_in;
                data_q <= data_in;
                size_q <= size_in;
            end
            if (state_q == MERGE) begin
                merged_q <= merged_d;
            end
        end
    end

    // Outputs decode from the state register only, so asserting reset drops
    // every strobe immediately rather than at the next edge.
    always_comb begin
        req_ready_out  = (state_q == IDLE);
        mem_re_out     = (state_q == READ);
        mem_we_out     = (state_q == WRITE);
        done_out       = (state_q == WRITE);
        misaligned_out = (state_q == ERROR);
        mem_addr_out   = addr_q[31:2];
        mem_wdata_out  = '0;
        if (state_q == WRITE) begin
            mem_wdata_out = size_q[1] ? data_q : merged_q;
        end
    end

endmodule

// File: tb/tb_data_memory_storer.sv
module tb_data_memory_storer;

    localparam int KIND_WORD = 0;
    localparam int KIND_RMW  = 1;
    localparam int KIND_MIS  = 2;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic [1:0]  reqSize;
    logic        done;
    logic        misaligned;
    logic [29:0] memAddr;
    logic        memRe;
    logic [31:0] memRdata;
    logic        memWe;
    logic [31:0] memWdata;

    // Bench-side RAM plus a preload port so the bench can seed words
    logic [31:0] ram [0:255];
    logic        preWe;
    logic [7:0]  preAddr;
    logic [31:0] preData;

    // Reference memory image: what the RAM should hold per the store rules
    logic [31:0] refMem [0:255];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        bit          doPre;
        logic [7:0]  preIdx;
        logic [31:0] preVal;
        int          kind;
        logic [31:0] expW;
    } vec_t;

    vec_t vecs [0:10];

    localparam int NRAND = 80;
    logic [31:0] rAddr [0:NRAND-1];
    logic [31:0] rData [0:NRAND-1];
    logic [1:0]  rSize [0:NRAND-1];

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    data_memory_storer dut (
        .clk_in         (clk),
        .reset_n_in     (resetN),
        .req_valid_in   (reqValid),
        .req_ready_out  (reqReady),
        .addr_in        (reqAddr),
        .data_in        (reqData),
        .size_in        (reqSize),
        .done_out       (done),
        .misaligned_out (misaligned),
        .mem_addr_out   (memAddr),
        .mem_re_out     (memRe),
        .mem_rdata_in   (memRdata),
        .mem_we_out     (memWe),
        .mem_wdata_out  (memWdata)
    );

    // Synchronous RAM: read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (preWe) ram[preAddr] <= preData;
        else if (memWe) ram[memAddr[7:0]] <= memWdata;
        if (memRe) memRdata <= ram[memAddr[7:0]];
    end

    // Counts one comparison and reports it if the values differ
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Access width in bytes from the size encoding
    function automatic int sizeBytes(input logic [1:0] size);
        if (size[1]) return 4;
        return (size == 2'b01) ? 2 : 1;
    endfunction

    // A store is misaligned when its address is not a multiple of its width
    function automatic int classify(input logic [31:0] addr, input logic [1:0] size);
        int nb = sizeBytes(size);
        if ((addr % nb) != 0) return KIND_MIS;
        return (nb == 4) ? KIND_WORD : KIND_RMW;
    endfunction

    // Little-endian store of the low nb bytes of data into the old word
    function automatic logic [31:0] modelStore(input logic [31:0] old, input logic [31:0] addr,
                                               input logic [31:0] data, input logic [1:0] size);
        int nb = sizeBytes(size);
        int shift = (addr % 4) * 8;
        logic [31:0] mask;
        if (nb == 4) return data;
        mask = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (old & ~(mask << shift)) | ((data & mask) << shift);
    endfunction

    // Seeds one RAM word and the reference image with the same value
    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        preWe = 1'b1;
        preAddr = idx;
        preData = val;
        @(posedge clk); #1;
        preWe = 1'b0;
        refMem[idx] = val;
    endtask

    // Presents one request, then walks the cycles after accept and compares
    // the strobe pattern, address and write data against the expected
    // latency for its kind. With keepValid the next request is presented
    // right after accept so it is taken on the first ready edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, input int kind,
                                 input logic [31:0] expW, input bit keepValid,
                                 input logic [31:0] nAddr, input logic [31:0] nData,
                                 input logic [1:0] nSize);
        int writeCyc;
        int readyCyc;
        logic [4:0] expFlags;
        reqAddr = addr;
        reqData = data;
        reqSize = size;
        reqValid = 1'b1;
        checkOutput("readyBeforeAccept", {63'd0, reqReady}, 64'd1);
        @(posedge clk); #1;
        if (keepValid) begin
            reqAddr = nAddr;
            reqData = nData;
            reqSize = nSize;
        end else begin
            reqValid = 1'b0;
        end
        writeCyc = (kind == KIND_WORD) ? 1 : (kind == KIND_RMW) ? 3 : 0;
        readyCyc = (kind == KIND_RMW) ? 4 : 2;
        for (int c = 1; c <= readyCyc; c++) begin
            expFlags = {c == readyCyc, (kind == KIND_RMW) && (c == 1), c == writeCyc,
                        c == writeCyc, (kind == KIND_MIS) && (c == 1)};
            checkOutput($sformatf("rdy/re/we/done/mis addr=%h c%0d", addr, c),
                        {59'd0, reqReady, memRe, memWe, done, misaligned}, {59'd0, expFlags});
            if (c < readyCyc)
                checkOutput($sformatf("memAddr addr=%h c%0d", addr, c), {34'd0, memAddr}, {34'd0, addr[31:2]});
            if (c == writeCyc)
                checkOutput($sformatf("wdata addr=%h", addr), {32'd0, memWdata}, {32'd0, expW});
            if (c < readyCyc) begin
                @(posedge clk); #1;
            end
        end
        if (kind != KIND_MIS) refMem[addr[9:2]] = expW;
    endtask

    // Main sequence: reset values, directed table, reset abort, back-to-back,
    // then randomized requests checked against the reference image
    initial begin
        logic [31:0] expW;
        int kind;
        bit keep;
        resetN = 1'b0;
        reqValid = 1'b0;
        reqAddr = '0;
        reqData = '0;
        reqSize = '0;
        preWe = 1'b0;
        preAddr = '0;
        preData = '0;
        #2;
        checkOutput("resetFlags", {59'd0, reqReady, memRe, memWe, done, misaligned}, 64'h10);
        checkOutput("resetAddr", {34'd0, memAddr}, 64'd0);
        checkOutput("resetWdata", {32'd0, memWdata}, 64'd0);
        #10 resetN = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 256; i++) preload(i[7:0], $urandom);

        vecs[0]  = '{32'h100, 32'hDEADBEEF, 2'b11, 1'b0, 8'h00, 32'h0,        KIND_WORD, 32'hDEADBEEF};
        vecs[1]  = '{32'h102, 32'hFFFFFFAB, 2'b00, 1'b1, 8'h40, 32'h11223344, KIND_RMW,  32'h11AB3344};
        vecs[2]  = '{32'h106, 32'h1234CAFE, 2'b01, 1'b1, 8'h41, 32'h55667788, KIND_RMW,  32'hCAFE7788};
        vecs[3]  = '{32'h104, 32'h1234CAFE, 2'b01, 1'b1, 8'h41, 32'h55667788, KIND_RMW,  32'h5566CAFE};
        vecs[4]  = '{32'h101, 32'h00001111, 2'b01, 1'b0, 8'h00, 32'h0,        KIND_MIS,  32'h0};
        vecs[5]  = '{32'h102, 32'h22222222, 2'b11, 1'b0, 8'h00, 32'h0,        KIND_MIS,  32'h0};
        vecs[6]  = '{32'h108, 32'h0000005A, 2'b00, 1'b1, 8'h42, 32'hA5A5A5A5, KIND_RMW,  32'hA5A5A55A};
        vecs[7]  = '{32'h10B, 32'h1234563C, 2'b00, 1'b0, 8'h00, 32'h0,        KIND_RMW,  32'h3CA5A55A};
        vecs[8]  = '{32'h10C, 32'h01020304, 2'b10, 1'b0, 8'h00, 32'h0,        KIND_WORD, 32'h01020304};
        vecs[9]  = '{32'h10E, 32'h01020304, 2'b10, 1'b0, 8'h00, 32'h0,        KIND_MIS,  32'h0};
        vecs[10] = '{32'h10D, 32'hFFFF0099, 2'b00, 1'b1, 8'h43, 32'h00000000, KIND_RMW,  32'h00009900};

        for (int i = 0; i <= 10; i++) begin
            if (vecs[i].doPre) preload(vecs[i].preIdx, vecs[i].preVal);
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].kind,
                          vecs[i].expW, 1'b0, '0, '0, '0);
        end

        // Reset asserted during MERGE of a byte store must abort it cleanly
        preload(8'h50, 32'h0BADF00D);
        reqAddr = 32'h141;
        reqData = 32'h000000EE;
        reqSize = 2'b00;
        reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        checkOutput("abortReadStrobe", {63'd0, memRe}, 64'd1);
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        checkOutput("abortFlags", {59'd0, reqReady, memRe, memWe, done, misaligned}, 64'h10);
        checkOutput("abortAddr", {34'd0, memAddr}, 64'd0);
        checkOutput("abortWdata", {32'd0, memWdata}, 64'd0);
        @(posedge clk); #1;
        checkOutput("abortFlagsLater", {59'd0, reqReady, memRe, memWe, done, misaligned}, 64'h10);
        checkOutput("abortRamUntouched", {32'd0, ram[8'h50]}, 64'h0BADF00D);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h200, 32'h00000001, 2'b11, KIND_WORD, 32'h00000001, 1'b0, '0, '0, '0);

        // Back-to-back with valid held high across the first operation
        preload(8'h00, 32'h12345678);
        applyStimulus(32'h000, 32'h00000000, 2'b10, KIND_WORD, 32'h00000000, 1'b1,
                      32'h003, 32'h0000007F, 2'b00);
        applyStimulus(32'h003, 32'h0000007F, 2'b00, KIND_RMW, 32'h7F000000, 1'b0, '0, '0, '0);
        checkOutput("b2bRamContents", {32'd0, ram[8'h00]}, 64'h7F000000);

        // Randomized requests, small address range so stores overlap
        for (int i = 0; i < NRAND; i++) begin
            rAddr[i] = $urandom_range(0, 255);
            rData[i] = $urandom;
            rSize[i] = 2'($urandom_range(0, 3));
        end
        for (int i = 0; i < NRAND; i++) begin
            kind = classify(rAddr[i], rSize[i]);
            expW = modelStore(refMem[rAddr[i][9:2]], rAddr[i], rData[i], rSize[i]);
            keep = (i < NRAND - 1) && ($urandom_range(0, 1) == 1);
            if (keep)
                applyStimulus(rAddr[i], rData[i], rSize[i], kind, expW, 1'b1,
                              rAddr[i+1], rData[i+1], rSize[i+1]);
            else
                applyStimulus(rAddr[i], rData[i], rSize[i], kind, expW, 1'b0, '0, '0, '0);
        end

        // Final sweep: RAM must match the reference image word for word
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++)
            checkOutput($sformatf("ramWord %0d", i), {32'd0, ram[i]}, {32'd0, refMem[i]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
